// File: rtl/add_serial_if.sv
// Handshake bundle for add_serial: operand request channel and result channel.
// With ADD_SERIAL_OVF_EN defined the bundle also carries the signed-overflow flag.
interface add_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;
`ifdef ADD_SERIAL_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, busy, ovf
    );
    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, busy
    );
    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, busy
    );
`endif
endinterface

// File: rtl/add_serial.sv
// Digit-serial adder: WIDTH-bit a+b+c_in, DIGIT bits per clock, LSB digit first.
// Optional macro ADD_SERIAL_OVF_EN adds a registered two's-complement overflow flag.
module add_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    add_serial_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef ADD_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    int               base;
    logic [DIGIT:0]   dig;
    logic [WIDTH-1:0] acc_step;

    function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    endfunction

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef ADD_SERIAL_OVF_EN
        ovf_d    = ovf_q;
`endif
        base     = int'(cnt_q) * DIGIT;
        dig      = digit_add(a_q[base +: DIGIT], b_q[base +: DIGIT], carry_q);
        acc_step = acc_q;
        acc_step[base +: DIGIT] = dig[DIGIT-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.c_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = acc_step;
                carry_d = dig[DIGIT];
                // The counter stops on the last step so it never wraps.
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = acc_step;
                    cout_d  = dig[DIGIT];
`ifdef ADD_SERIAL_OVF_EN
                    ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ acc_step[WIDTH-1] ^ dig[DIGIT];
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef ADD_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = cout_q;
`ifdef ADD_SERIAL_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_add_serial.sv
// Scoreboard bench for add_serial: queued reference results, negedge monitor,
// directed corner cases, backpressure, mid-run reset, random traffic, DIGIT=1/8 configs.
module tb_add_serial;
    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit rnd_done = 1'b0;

    add_serial_if #(.WIDTH(W)) bus ();
    add_serial #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    add_serial_if #(.WIDTH(W)) bus1 ();
    add_serial #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    add_serial_if #(.WIDTH(W)) bus8 ();
    add_serial #(.WIDTH(W), .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    res_t exp_q[$];
    int   acc_q[$];

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int   u;
        int   s;
        res_t r;
        u   = int'(a) + int'(b) + int'(c);
        r.s = u[W-1:0];
        r.c = u[W];
        s   = int'($signed(a)) + int'($signed(b)) + int'(c);
        r.v = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
        return r;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented result, checks latency and hold behaviour.
    logic         prev_ov = 1'b0;
    logic [W-1:0] last_s  = '0;
    logic         last_c  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov <= 1'b0;
            last_s  <= '0;
            last_c  <= 1'b0;
            exp_q.delete();
            acc_q.delete();
        end else begin
            check("ready_vs_busy", int'(bus.in_ready), int'(!bus.busy));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stale_result", 1, 0);
                end else begin
                    if (!prev_ov && acc_q.size() > 0) check("latency", cyc - acc_q.pop_front(), N);
                    check("sum", int'(bus.sum), int'(exp_q[0].s));
                    check("c_out", int'(bus.c_out), int'(exp_q[0].c));
`ifdef ADD_SERIAL_OVF_EN
                    check("ovf", int'(bus.ovf), int'(exp_q[0].v));
`endif
                    if (bus.out_ready) begin
                        last_s <= exp_q[0].s;
                        last_c <= exp_q[0].c;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("sum_hold", int'(bus.sum), int'(last_s));
                check("c_out_hold", int'(bus.c_out), int'(last_c));
            end
            prev_ov <= bus.out_valid;
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int gap);
        int n;
        n = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = c;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            exp_q.push_back(model(a, b, c));
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.c_in     = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", int'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        int lat1;
        int lat8;
        logic [W-1:0] s1;
        logic [W-1:0] s8;
        logic c1;
        logic c8;

        bus.in_valid  = 1'b0; bus.a  = '0; bus.b  = '0; bus.c_in  = 1'b0; bus.out_ready  = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0; bus1.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0; bus8.out_ready = 1'b1;

        #12;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_sum", int'(bus.sum), 0);
        check("rst_c_out", int'(bus.c_out), 0);
        check("rst_busy", int'(bus.busy), 0);
`ifdef ADD_SERIAL_OVF_EN
        check("rst_ovf", int'(bus.ovf), 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(8'hFF, 8'h01, 1'b0, 0); drain();
        issue(8'h7F, 8'h01, 1'b0, 1); drain();
        issue(8'h00, 8'h00, 1'b1, 1); drain();
        issue(8'h80, 8'h80, 1'b1, 0); drain();

        // Backpressure: result waits while new operands are offered.
        bus.out_ready = 1'b0;
        issue(8'h3C, 8'h47, 1'b0, 0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_result_seen", int'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.c_in = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_sum", int'(bus.sum), 8'h83);
            check("bp_c_out", int'(bus.c_out), 0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_out_valid", int'(bus.out_valid), 0);
        check("bp_idle_in_ready", int'(bus.in_ready), 1);
        exp_q.push_back(model(8'h12, 8'h34, 1'b1));
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", int'(bus.busy), 1);
        drain();

        // Asynchronous reset two steps into an operation.
        issue(8'h55, 8'h66, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(bus.in_ready), 1);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_sum", int'(bus.sum), 0);
        check("mid_rst_c_out", int'(bus.c_out), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_rst_no_stale", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;

        fork
            begin
                for (int i = 0; i < 1000; i++)
                    issue(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // DIGIT=1 and DIGIT=8 instances, driven in lockstep.
        bus1.in_valid = 1'b1; bus1.a = 8'hA5; bus1.b = 8'h5B; bus1.c_in = 1'b1;
        bus8.in_valid = 1'b1; bus8.a = 8'hA5; bus8.b = 8'h5B; bus8.c_in = 1'b1;
        @(negedge clk);
        check("cfg1_in_ready", int'(bus1.in_ready), 1);
        check("cfg8_in_ready", int'(bus8.in_ready), 1);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
        lat1 = -1; lat8 = -1; s1 = '0; s8 = '0; c1 = 1'b0; c8 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus1.out_valid && lat1 < 0) begin lat1 = cyc - acc; s1 = bus1.sum; c1 = bus1.c_out; end
            if (bus8.out_valid && lat8 < 0) begin lat8 = cyc - acc; s8 = bus8.sum; c8 = bus8.c_out; end
        end
        check("cfg1_latency", lat1, 8);
        check("cfg8_latency", lat8, 1);
        check("cfg1_sum", int'(s1), 8'h01);
        check("cfg1_c_out", int'(c1), 1);
        check("cfg8_sum", int'(s8), 8'h01);
        check("cfg8_c_out", int'(c8), 1);
        check("cfg1_back_idle", int'(bus1.in_ready), 1);
        check("cfg8_back_idle", int'(bus8.in_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
